config_cmd_parser: RTL and testbench



---
 rtl/config_cmd_pkg.sv | 24 ++
 rtl/cmd_gap_timer.sv | 36 +++
 rtl/config_cmd_parser.sv | 193 +++++++++++++++++++
 tb/tb_config_cmd_parser.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/config_cmd_pkg.sv
// Shared types and defaults for the ground-command frame parser.
// State encoding, default header/address constants and the saturating counter helper.
package config_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_ADDR,
        ST_DHI,
        ST_DLO,
        ST_CSUM,
        ST_COMMIT
    } cmd_state_e;

    localparam logic [7:0]  HDR0_DEFAULT     = 8'hEB;
    localparam logic [7:0]  HDR1_DEFAULT     = 8'h90;
    localparam logic [7:0]  MAX_ADDR_DEFAULT = 8'h13;
    localparam logic [15:0] TIMEOUT_DEFAULT  = 16'd50000;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/cmd_gap_timer.sv
// Inter-byte gap counter: clears on clr_in, counts while en_in, pulses
// expire_out on the cycle the count sits at TIMEOUT_CYCLES-1.
module cmd_gap_timer #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic clr_in,
    input  logic en_in,
    output logic expire_out
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_in) begin
            cnt_d = 16'd0;
        end else if (en_in) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A clear on the expiry cycle means a byte arrived, and that byte wins.
    assign expire_out = en_in && !clr_in && (cnt_q == TIMEOUT_CYCLES - 16'd1);

endmodule

// File: rtl/config_cmd_parser.sv
// Command frame parser: HDR0 HDR1 ADDR DATA_HI DATA_LO [CSUM] -> one-cycle register write.
// Define CMD_CHECKSUM_EN for the six-byte frame with checksum; otherwise frames are five bytes.
module config_cmd_parser
    import config_cmd_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter logic [7:0]  MAX_ADDR       = MAX_ADDR_DEFAULT,
    parameter logic [7:0]  HDR0           = HDR0_DEFAULT,
    parameter logic [7:0]  HDR1           = HDR1_DEFAULT
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [7:0]  rx_data_in,
    input  logic        rx_valid_in,
    output logic        wr_out,
    output logic [7:0]  wr_addr_out,
    output logic [15:0] data_out,
    output logic        busy_out,
    output logic [15:0] frame_ok_cnt_out,
    output logic [7:0]  csum_err_cnt_out,
    output logic [7:0]  addr_err_cnt_out,
    output logic [7:0]  tmo_err_cnt_out,
    output cmd_state_e  state_dbg_out
);

    cmd_state_e  state_q, state_d;
    logic [7:0]  addr_sh_q, addr_sh_d;
    logic [7:0]  dhi_sh_q, dhi_sh_d;
    logic        wr_q, wr_d;
    logic        busy_q, busy_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [15:0] data_q, data_d;
    logic [15:0] frame_ok_cnt_q, frame_ok_cnt_d;
    logic [7:0]  addr_err_cnt_q, addr_err_cnt_d;
    logic [7:0]  tmo_err_cnt_q, tmo_err_cnt_d;
    logic        gap_en, gap_clr, gap_expire;
    logic        do_commit;
    logic [15:0] commit_data;
`ifdef CMD_CHECKSUM_EN
    logic [7:0]  dlo_sh_q, dlo_sh_d;
    logic [7:0]  csum_err_cnt_q, csum_err_cnt_d;
    logic [7:0]  csum_calc;

    assign csum_calc = addr_sh_q + dhi_sh_q + dlo_sh_q;
`endif

    assign gap_en  = (state_q != ST_IDLE) && (state_q != ST_COMMIT);
    assign gap_clr = rx_valid_in || (state_q == ST_IDLE);

    cmd_gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .clr_in    (gap_clr),
        .en_in     (gap_en),
        .expire_out(gap_expire)
    );

    always_comb begin
        state_d        = state_q;
        addr_sh_d      = addr_sh_q;
        dhi_sh_d       = dhi_sh_q;
        wr_addr_d      = wr_addr_q;
        data_d         = data_q;
        frame_ok_cnt_d = frame_ok_cnt_q;
        addr_err_cnt_d = addr_err_cnt_q;
        tmo_err_cnt_d  = tmo_err_cnt_q;
        do_commit      = 1'b0;
        commit_data    = 16'h0000;
`ifdef CMD_CHECKSUM_EN
        dlo_sh_d       = dlo_sh_q;
        csum_err_cnt_d = csum_err_cnt_q;
`endif
        unique case (state_q)
            // COMMIT treats an incoming byte like IDLE so back-to-back frames survive.
            ST_IDLE, ST_COMMIT: begin
                state_d = (rx_valid_in && rx_data_in == HDR0) ? ST_HDR : ST_IDLE;
            end
            ST_HDR: if (rx_valid_in) begin
                if (rx_data_in == HDR1)      state_d = ST_ADDR;
                else if (rx_data_in == HDR0) state_d = ST_HDR;
                else                         state_d = ST_IDLE;
            end
            ST_ADDR: if (rx_valid_in) begin
                addr_sh_d = rx_data_in;
                state_d   = ST_DHI;
            end
            ST_DHI: if (rx_valid_in) begin
                dhi_sh_d = rx_data_in;
                state_d  = ST_DLO;
            end
`ifdef CMD_CHECKSUM_EN
            ST_DLO: if (rx_valid_in) begin
                dlo_sh_d = rx_data_in;
                state_d  = ST_CSUM;
            end
            ST_CSUM: if (rx_valid_in) begin
                if (rx_data_in != csum_calc) begin
                    csum_err_cnt_d = sat_inc8(csum_err_cnt_q);
                    state_d        = ST_IDLE;
                end else if (addr_sh_q > MAX_ADDR) begin
                    addr_err_cnt_d = sat_inc8(addr_err_cnt_q);
                    state_d        = ST_IDLE;
                end else begin
                    do_commit   = 1'b1;
                    commit_data = {dhi_sh_q, dlo_sh_q};
                end
            end
`else
            ST_DLO: if (rx_valid_in) begin
                if (addr_sh_q > MAX_ADDR) begin
                    addr_err_cnt_d = sat_inc8(addr_err_cnt_q);
                    state_d        = ST_IDLE;
                end else begin
                    do_commit   = 1'b1;
                    commit_data = {dhi_sh_q, rx_data_in};
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (do_commit) begin
            state_d        = ST_COMMIT;
            wr_addr_d      = addr_sh_q;
            data_d         = commit_data;
            frame_ok_cnt_d = frame_ok_cnt_q + 16'd1;
        end

        if (gap_expire && !rx_valid_in) begin
            state_d       = ST_IDLE;
            tmo_err_cnt_d = sat_inc8(tmo_err_cnt_q);
            addr_sh_d     = 8'h00;
            dhi_sh_d      = 8'h00;
`ifdef CMD_CHECKSUM_EN
            dlo_sh_d      = 8'h00;
`endif
        end

        wr_d   = (state_d == ST_COMMIT);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q        <= ST_IDLE;
            addr_sh_q      <= 8'h00;
            dhi_sh_q       <= 8'h00;
            wr_q           <= 1'b0;
            busy_q         <= 1'b0;
            wr_addr_q      <= 8'h00;
            data_q         <= 16'h0000;
            frame_ok_cnt_q <= 16'h0000;
            addr_err_cnt_q <= 8'h00;
            tmo_err_cnt_q  <= 8'h00;
`ifdef CMD_CHECKSUM_EN
            dlo_sh_q       <= 8'h00;
            csum_err_cnt_q <= 8'h00;
`endif
        end else begin
            state_q        <= state_d;
            addr_sh_q      <= addr_sh_d;
            dhi_sh_q       <= dhi_sh_d;
            wr_q           <= wr_d;
            busy_q         <= busy_d;
            wr_addr_q      <= wr_addr_d;
            data_q         <= data_d;
            frame_ok_cnt_q <= frame_ok_cnt_d;
            addr_err_cnt_q <= addr_err_cnt_d;
            tmo_err_cnt_q  <= tmo_err_cnt_d;
`ifdef CMD_CHECKSUM_EN
            dlo_sh_q       <= dlo_sh_d;
            csum_err_cnt_q <= csum_err_cnt_d;
`endif
        end
    end

    assign wr_out           = wr_q;
    assign wr_addr_out      = wr_addr_q;
    assign data_out         = data_q;
    assign busy_out         = busy_q;
    assign frame_ok_cnt_out = frame_ok_cnt_q;
    assign addr_err_cnt_out = addr_err_cnt_q;
    assign tmo_err_cnt_out  = tmo_err_cnt_q;
    assign state_dbg_out    = state_q;
`ifdef CMD_CHECKSUM_EN
    assign csum_err_cnt_out = csum_err_cnt_q;
`else
    assign csum_err_cnt_out = 8'h00;
`endif

endmodule

// File: tb/tb_config_cmd_parser.sv
// Directed bench for config_cmd_parser; frame length follows CMD_CHECKSUM_EN.
module tb_config_cmd_parser;
    import config_cmd_pkg::*;

    localparam logic [15:0] TMO = 16'd20;
`ifdef CMD_CHECKSUM_EN
    localparam int FRAME_LEN = 6;
`else
    localparam int FRAME_LEN = 5;
`endif

    logic        clk_in;
    logic        rst_in;
    logic [7:0]  rx_data_in;
    logic        rx_valid_in;
    logic        wr_out;
    logic [7:0]  wr_addr_out;
    logic [15:0] data_out;
    logic        busy_out;
    logic [15:0] frame_ok_cnt_out;
    logic [7:0]  csum_err_cnt_out;
    logic [7:0]  addr_err_cnt_out;
    logic [7:0]  tmo_err_cnt_out;
    cmd_state_e  state_dbg_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [23:0] exp_q[$];
    logic [23:0] obs_q[$];
    int wr_cyc_q[$];
    logic [15:0] exp_ok = 16'd0;

    config_cmd_parser #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rx_data_in      (rx_data_in),
        .rx_valid_in     (rx_valid_in),
        .wr_out          (wr_out),
        .wr_addr_out     (wr_addr_out),
        .data_out        (data_out),
        .busy_out        (busy_out),
        .frame_ok_cnt_out(frame_ok_cnt_out),
        .csum_err_cnt_out(csum_err_cnt_out),
        .addr_err_cnt_out(addr_err_cnt_out),
        .tmo_err_cnt_out (tmo_err_cnt_out),
        .state_dbg_out   (state_dbg_out)
    );

    // clock / reset
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    // write monitor, sampled mid-cycle
    always @(negedge clk_in) begin
        if (wr_out === 1'b1) begin
            obs_q.push_back({wr_addr_out, data_out});
            wr_cyc_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // driver tasks: each call occupies one cycle slot
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk_in);
        #1;
        rx_valid_in = 1'b1;
        rx_data_in  = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
            rx_valid_in = 1'b0;
            rx_data_in  = 8'h00;
        end
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [15:0] d, input logic [7:0] csum_xor);
        logic [7:0] cs;
        cs = a + d[15:8] + d[7:0];
        send_byte(HDR0_DEFAULT);
        send_byte(HDR1_DEFAULT);
        send_byte(a);
        send_byte(d[15:8]);
        send_byte(d[7:0]);
`ifdef CMD_CHECKSUM_EN
        send_byte(cs ^ csum_xor);
`else
        if (csum_xor != 8'h00) cs = 8'h00;
`endif
    endtask

    task automatic expect_write(input logic [7:0] a, input logic [15:0] d);
        exp_q.push_back({a, d});
        exp_ok = exp_ok + 16'd1;
    endtask

    // scoreboard: compare observed writes against the expected queue
    task automatic check_writes(input string tag);
        check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            check({tag, "_wr"}, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr"}, 32'(wr_out), 32'd0);
        check({tag, "_busy"}, 32'(busy_out), 32'd0);
        check({tag, "_addr"}, 32'(wr_addr_out), 32'h00);
        check({tag, "_data"}, 32'(data_out), 32'h0000);
        check({tag, "_ok"}, 32'(frame_ok_cnt_out), 32'd0);
        check({tag, "_csum"}, 32'(csum_err_cnt_out), 32'd0);
        check({tag, "_aerr"}, 32'(addr_err_cnt_out), 32'd0);
        check({tag, "_tmo"}, 32'(tmo_err_cnt_out), 32'd0);
        check({tag, "_state"}, 32'(state_dbg_out), 32'(ST_IDLE));
    endtask

    initial begin
        int gap;
        rst_in      = 1'b0;
        rx_valid_in = 1'b0;
        rx_data_in  = 8'h00;
        repeat (3) @(posedge clk_in);
        #1;
        check_all_zero("reset");
        rst_in = 1'b1;
        idle(2);

        // good frame, busy during header
        send_byte(8'hEB);
        send_byte(8'h90);
        check("busy_in_frame", 32'(busy_out), 32'd1);
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
`ifdef CMD_CHECKSUM_EN
        send_byte(8'h48);
`endif
        expect_write(8'h02, 16'h1234);
        idle(3);
        check_writes("good");
        check("good_addr", 32'(wr_addr_out), 32'h02);
        check("good_data", 32'(data_out), 32'h1234);
        check("good_ok", 32'(frame_ok_cnt_out), 32'(exp_ok));
        check("good_busy", 32'(busy_out), 32'd0);

`ifdef CMD_CHECKSUM_EN
        // bad checksum
        send_frame(8'h02, 16'h1234, 8'h01);
        idle(3);
        check_writes("csum");
        check("csum_cnt", 32'(csum_err_cnt_out), 32'd1);
        check("csum_hold_addr", 32'(wr_addr_out), 32'h02);
        check("csum_hold_data", 32'(data_out), 32'h1234);
`else
        check("csum_tied", 32'(csum_err_cnt_out), 32'd0);
`endif

        // out-of-range address
        send_frame(8'h20, 16'h0001, 8'h00);
        idle(3);
        check_writes("aerr");
        check("aerr_cnt", 32'(addr_err_cnt_out), 32'd1);
        check("aerr_hold_addr", 32'(wr_addr_out), 32'h02);
        check("aerr_hold_data", 32'(data_out), 32'h1234);

        // highest legal address
        send_frame(8'h13, 16'h5555, 8'h00);
        expect_write(8'h13, 16'h5555);
        idle(3);
        check_writes("maxaddr");
        check("maxaddr_aerr", 32'(addr_err_cnt_out), 32'd1);

        // timeout on a partial frame, then a wrapping-checksum frame
        send_byte(8'hEB);
        send_byte(8'h90);
        send_byte(8'h05);
        idle(int'(TMO) + 1);
        check("tmo_cnt", 32'(tmo_err_cnt_out), 32'd1);
        check("tmo_busy", 32'(busy_out), 32'd0);
        check_writes("tmo_nowr");
        send_frame(8'h05, 16'hABCD, 8'h00);
        expect_write(8'h05, 16'hABCD);
        idle(3);
        check_writes("after_tmo");

        // byte arriving on the expiry cycle wins
        send_byte(8'hEB);
        send_byte(8'h90);
        send_byte(8'h07);
        idle(int'(TMO) - 1);
        send_byte(8'h01);
        send_byte(8'h02);
`ifdef CMD_CHECKSUM_EN
        send_byte(8'h0A);
`endif
        expect_write(8'h07, 16'h0102);
        idle(3);
        check_writes("expiry_edge");
        check("expiry_edge_tmo", 32'(tmo_err_cnt_out), 32'd1);

        // header resync
        send_byte(8'hEB);
        send_frame(8'h00, 16'h0001, 8'h00);
        expect_write(8'h00, 16'h0001);
        idle(3);
        check_writes("resync");
        check("resync_ok", 32'(frame_ok_cnt_out), 32'(exp_ok));

        // back-to-back frames
        wr_cyc_q.delete();
        send_frame(8'h01, 16'h1111, 8'h00);
        send_frame(8'h02, 16'h2222, 8'h00);
        expect_write(8'h01, 16'h1111);
        expect_write(8'h02, 16'h2222);
        idle(3);
        gap = (wr_cyc_q.size() == 2) ? wr_cyc_q[1] - wr_cyc_q[0] : -1;
        check("b2b_spacing", 32'(gap), 32'(FRAME_LEN));
        check_writes("b2b");
        check("b2b_ok", 32'(frame_ok_cnt_out), 32'(exp_ok));
        check("b2b_csum", 32'(csum_err_cnt_out), 32'd1 * ((FRAME_LEN == 6) ? 32'd1 : 32'd0));

        // reset in the middle of a frame
        send_byte(8'hEB);
        send_byte(8'h90);
        send_byte(8'h03);
        send_byte(8'h11);
        idle(1);
        rst_in = 1'b0;
        #2;
        check_all_zero("midreset");
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        idle(3);
        check_writes("midreset");
        exp_ok = 16'd0;
        send_frame(8'h04, 16'h00FF, 8'h00);
        expect_write(8'h04, 16'h00FF);
        idle(3);
        check_writes("post_reset");
        check("post_reset_ok", 32'(frame_ok_cnt_out), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
